// File: rtl/anton_neopixel_stream_sequencer.sv
// NeoPixel stream sequencer: sub-bit/bit/channel/pixel indices, frame/reset timing and buffer byte address.
// Optional ANTON_STREAM_FRAMECNT_EN adds a 16-bit wrapping frameCount output.
`ifndef BUFFER_END_DEFAULT
`define BUFFER_END_DEFAULT 255
`endif
`ifndef RESET_DELAY_DEFAULT
`define RESET_DELAY_DEFAULT 320
`endif

module anton_neopixel_stream_sequencer #(
    parameter int unsigned BUFFER_END    = `BUFFER_END_DEFAULT,
    parameter int unsigned RESET_DELAY   = `RESET_DELAY_DEFAULT,
    parameter int unsigned CHANNELS      = 3,
    parameter int unsigned PATTERN_STEPS = 8,
    localparam int unsigned BUFFER_BITS  = $clog2(BUFFER_END + 1)
) (
    input  logic                   clk6_4mhz,
    input  logic                   rstn,
    input  logic                   regCtrlInit,
    input  logic                   regCtrlRun,
    input  logic                   regCtrlLoop,
    input  logic                   regCtrlLimit,
    input  logic                   regCtrl32bit,
    input  logic [12:0]            regMax,
    input  logic [7:0]             regOrder,
    input  logic                   initSlow,
    output logic                   initSlowDone,
    output logic [3:0]             bitPatternIx,
    output logic [2:0]             pixelBitIx,
    output logic [1:0]             channelIx,
    output logic [1:0]             channelMapped,
    output logic [BUFFER_BITS-1:0] pixelIx,
    output logic [BUFFER_BITS-1:0] pixelIxMax,
    output logic [BUFFER_BITS-1:0] byteAddr,
    output logic [1:0]             state,
    output logic                   streamOutput,
    output logic                   streamReset,
    output logic                   streamBitOf,
    output logic                   streamChannelOf,
    output logic                   streamPixelOf,
    output logic                   streamSyncOf,
    output logic                   frameDone
`ifdef ANTON_STREAM_FRAMECNT_EN
    ,
    output logic [15:0]            frameCount
`endif
);

    localparam int unsigned DLY_BITS = $clog2(RESET_DELAY);
    localparam logic [3:0]             PAT_LAST = 4'(PATTERN_STEPS - 1);
    localparam logic [1:0]             CH_LAST  = 2'(CHANNELS - 1);
    localparam logic [DLY_BITS-1:0]    DLY_LAST = DLY_BITS'(RESET_DELAY - 1);
    localparam logic [BUFFER_BITS-1:0] BUF_LAST = BUFFER_BITS'(BUFFER_END);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_TRANSMIT = 2'd1,
        ST_RESET    = 2'd2,
        ST_HALT     = 2'd3
    } state_t;

    state_t                 r_state, w_state_nxt;
    logic [3:0]             r_bp, w_bp_nxt;
    logic [2:0]             r_pbi, w_pbi_nxt;
    logic [1:0]             r_ch, w_ch_nxt;
    logic [BUFFER_BITS-1:0] r_pix, w_pix_nxt;
    logic [DLY_BITS-1:0]    r_dly, w_dly_nxt;
    logic                   r_init_done;

    logic                   w_active, w_tx, w_rs;
    logic                   w_pattern_of, w_bit_of, w_ch_of, w_pix_of, w_sync_of;
    logic [BUFFER_BITS-1:0] w_last_byte, w_pix_max;
    logic [1:0]             w_mapped;

    // Overflow chain: each strobe qualifies the next coarser one
    assign w_active     = regCtrlRun && !regCtrlInit;
    assign w_tx         = w_active && (r_state == ST_TRANSMIT);
    assign w_rs         = w_active && (r_state == ST_RESET);
    assign w_pattern_of = w_tx && (r_bp == PAT_LAST);
    assign w_bit_of     = w_pattern_of && (r_pbi == 3'd0);
    assign w_ch_of      = w_bit_of && (r_ch == CH_LAST);
    assign w_last_byte  = regCtrlLimit ? regMax[BUFFER_BITS-1:0] : BUF_LAST;
    assign w_pix_max    = regCtrl32bit ? (w_last_byte >> 2) : w_last_byte;
    assign w_pix_of     = w_ch_of && (r_pix >= w_pix_max);
    assign w_sync_of    = w_rs && (r_dly == DLY_LAST);
    assign w_mapped     = regOrder[{r_ch, 1'b0} +: 2];

    always_ff @(posedge clk6_4mhz or negedge rstn) begin
        if (!rstn) begin
            r_state     <= ST_IDLE;
            r_bp        <= '0;
            r_pbi       <= '0;
            r_ch        <= '0;
            r_pix       <= '0;
            r_dly       <= '0;
            r_init_done <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_bp        <= w_bp_nxt;
            r_pbi       <= w_pbi_nxt;
            r_ch        <= w_ch_nxt;
            r_pix       <= w_pix_nxt;
            r_dly       <= w_dly_nxt;
            r_init_done <= initSlow;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_bp_nxt    = r_bp;
        w_pbi_nxt   = r_pbi;
        w_ch_nxt    = r_ch;
        w_pix_nxt   = r_pix;
        w_dly_nxt   = r_dly;
        case (r_state)
            ST_IDLE: begin
                if (w_active) w_state_nxt = ST_TRANSMIT;
            end
            ST_TRANSMIT: begin
                if (w_tx) begin
                    w_bp_nxt = r_bp + 4'd1;
                    if (w_pattern_of) begin
                        w_bp_nxt  = '0;
                        w_pbi_nxt = r_pbi - 3'd1;
                        if (w_bit_of) begin
                            w_pbi_nxt = 3'd7;
                            w_ch_nxt  = r_ch + 2'd1;
                            if (w_ch_of) begin
                                w_ch_nxt = '0;
                                if (w_pix_of) begin
                                    w_pix_nxt   = '0;
                                    w_state_nxt = ST_RESET;
                                end else begin
                                    w_pix_nxt = r_pix + BUFFER_BITS'(1);
                                end
                            end
                        end
                    end
                end
            end
            ST_RESET: begin
                if (w_rs) begin
                    w_dly_nxt = r_dly + DLY_BITS'(1);
                    if (w_sync_of) begin
                        w_dly_nxt   = '0;
                        w_state_nxt = regCtrlLoop ? ST_TRANSMIT : ST_HALT;
                    end
                end
            end
            default: begin
                // HALT waits for software to drop run so one-shot mode cannot re-trigger
                if (!regCtrlRun) w_state_nxt = ST_IDLE;
            end
        endcase
        if (initSlow) begin
            w_state_nxt = ST_IDLE;
            w_bp_nxt    = '0;
            w_pbi_nxt   = 3'd7;
            w_ch_nxt    = '0;
            w_pix_nxt   = '0;
            w_dly_nxt   = '0;
        end
    end

`ifdef ANTON_STREAM_FRAMECNT_EN
    logic [15:0] r_frame_cnt;

    always_ff @(posedge clk6_4mhz or negedge rstn) begin
        if (!rstn) begin
            r_frame_cnt <= '0;
        end else if (initSlow) begin
            r_frame_cnt <= '0;
        end else if (w_sync_of) begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
        end
    end

    assign frameCount = r_frame_cnt;
`endif

    assign initSlowDone    = r_init_done;
    assign bitPatternIx    = r_bp;
    assign pixelBitIx      = r_pbi;
    assign channelIx       = r_ch;
    assign channelMapped   = w_mapped;
    assign pixelIx         = r_pix;
    assign pixelIxMax      = w_pix_max;
    assign byteAddr        = regCtrl32bit ? {r_pix[BUFFER_BITS-3:0], w_mapped} : r_pix;
    assign state           = r_state;
    assign streamOutput    = w_tx;
    assign streamReset     = w_rs;
    assign streamBitOf     = w_bit_of;
    assign streamChannelOf = w_ch_of;
    assign streamPixelOf   = w_pix_of;
    assign streamSyncOf    = w_sync_of;
    assign frameDone       = w_sync_of;

endmodule
